// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// A word accepted on ld/ready is shifted out one bit per clock, head bit
// selected by MSB_FIRST. A load in the last-bit cycle chains words with no gap.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] pin,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic             busy
);

    localparam int                CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_last;
    logic               w_accept;
    logic               w_head;

    assign w_last   = (r_cnt == '0);
    assign w_accept = ready & ld;
    assign w_head   = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

    // State register; reset drops straight back to IDLE, aborting any word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and outputs, decoded from registered state only.
    always_comb begin
        w_next     = r_state;
        ready      = 1'b0;
        busy       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        case (r_state)
            IDLE: begin
                // Held low while reset is asserted.
                ready = rst;
                if (ld && rst) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
                if (w_last) begin
                    done   = 1'b1;
                    ready  = 1'b1;
                    w_next = ld ? SHIFT : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Serial data is forced low outside valid cycles.
    assign sout = sout_valid & w_head;

    // Shift register and bit counter: load on accept, advance while shifting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shreg <= pin;
            r_cnt   <= CNT_LAST;
        end else if (r_state == SHIFT && !w_last) begin
            if (MSB_FIRST) begin
                r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            end else begin
                r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
            end
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx: an MSB-first and an LSB-first instance share the
// same stimulus; expected serial bits are queued per instance and checked by
// a monitor whenever sout_valid is high.
module tb_piso_tx;

    logic       clk;
    logic       rst;
    logic       ld;
    logic [3:0] pin;

    logic rdy0, so0, sv0, dn0, bz0;
    logic rdy1, so1, sv1, dn1, bz1;

    int n_chk  = 0;
    int n_fail = 0;

    // Each entry: {expected sout, expected done}
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .ld(ld), .pin(pin),
        .ready(rdy0), .sout(so0), .sout_valid(sv0), .done(dn0), .busy(bz0)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .ld(ld), .pin(pin),
        .ready(rdy1), .sout(so1), .sout_valid(sv1), .done(dn1), .busy(bz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the first nbits of word w in each instance's bit order.
    task automatic push_word(input logic [3:0] w, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            q0.push_back({w[3-k], (k == 3)});
            q1.push_back({w[k],   (k == 3)});
        end
    endtask

    task automatic mon(input int which, input logic sv, input logic so, input logic dn);
        logic [1:0] e;
        if (sv) begin
            if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
                chk($sformatf("extra_bit_dut%0d", which), 32'(sv), 32'd0);
            end else begin
                e = (which == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("sout_dut%0d", which), 32'(so), 32'(e[1]));
                chk($sformatf("done_dut%0d", which), 32'(dn), 32'(e[0]));
            end
        end else begin
            chk($sformatf("idle_sout_dut%0d", which), 32'(so), 32'd0);
            chk($sformatf("idle_done_dut%0d", which), 32'(dn), 32'd0);
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        mon(0, sv0, so0, dn0);
        mon(1, sv1, so1, dn1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present w with ld=1 until accepted (ready seen before an edge), then drop ld.
    task automatic issue(input logic [3:0] w);
        int guard;
        pin = w;
        ld  = 1'b1;
        guard = 0;
        while (!rdy0 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) chk("issue_timeout", 32'(guard), 32'd0);
        push_word(w, 4);
        tick();
        ld = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [3:0] cont_tab [12];

    initial begin
        rst = 1'b0;
        ld  = 1'b0;
        pin = 4'h0;
        cont_tab = '{4'h3, 4'hF, 4'h0, 4'h9, 4'hC, 4'h1, 4'h2, 4'h8,
                     4'h6, 4'h7, 4'hE, 4'hA};

        // Reset state
        idle_cycles(2);
        chk("rst_ready0", 32'(rdy0), 32'd0);
        chk("rst_ready1", 32'(rdy1), 32'd0);
        chk("rst_busy0",  32'(bz0),  32'd0);
        chk("rst_valid0", 32'(sv0),  32'd0);
        chk("rst_done0",  32'(dn0),  32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready0", 32'(rdy0), 32'd1);
        chk("post_rst_ready1", 32'(rdy1), 32'd1);
        tick();

        // Single word 1010
        issue(4'b1010);
        chk("shift_busy0",  32'(bz0),  32'd1);
        chk("shift_ready0", 32'(rdy0), 32'd0);
        idle_cycles(5);
        chk("idle_ready0", 32'(rdy0), 32'd1);
        chk("idle_busy0",  32'(bz0),  32'd0);
        chk("idle_busy1",  32'(bz1),  32'd0);

        // Back-to-back 1010 then 0101, busy must never drop
        issue(4'b1010);
        issue(4'b0101);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_busy0", 32'(bz0), 32'd1);
            tick();
        end
        chk("b2b_last_busy0", 32'(bz0), 32'd1);
        idle_cycles(3);
        chk("b2b_end_busy0", 32'(bz0), 32'd0);

        // Load requests while shifting are ignored
        issue(4'b1101);
        ld  = 1'b1;
        pin = 4'b0000;
        idle_cycles(2);
        ld  = 1'b0;
        idle_cycles(6);
        chk("ignore_idle_busy0", 32'(bz0), 32'd0);

        // Reset in the middle of 1011 (only two bits appear)
        pin = 4'b1011;
        ld  = 1'b1;
        push_word(4'b1011, 2);
        tick();
        ld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_valid0", 32'(sv0),  32'd0);
        chk("midrst_sout0",  32'(so0),  32'd0);
        chk("midrst_done0",  32'(dn0),  32'd0);
        chk("midrst_busy0",  32'(bz0),  32'd0);
        chk("midrst_ready0", 32'(rdy0), 32'd0);
        chk("midrst_valid1", 32'(sv1),  32'd0);
        idle_cycles(2);
        chk("midrst_hold_ready0", 32'(rdy0), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rel_ready0", 32'(rdy0), 32'd1);
        // Load on the first edge after release
        pin = 4'b0110;
        ld  = 1'b1;
        push_word(4'b0110, 4);
        tick();
        ld = 1'b0;
        idle_cycles(6);

        // Continuous ld with pin changing every cycle
        ld = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pin = cont_tab[i];
            chk("cont_ready0", 32'(rdy0), 32'((i % 4) == 0));
            if ((i % 4) == 0) push_word(cont_tab[i], 4);
            tick();
        end
        ld = 1'b0;
        idle_cycles(6);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4: shift word width in bits, legal values 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts pin[WIDTH-1] first; 0 shifts pin[0] first.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low; 0 resets the block immediately.
REQ-005 Port ld, input, 1: load request, qualified by ready.
REQ-006 Port pin, input, WIDTH: parallel word to transmit, sampled only when ld and ready are both 1.
REQ-007 Port ready, output, 1: block accepts a load on this edge.
REQ-008 Port sout, output, 1: serial data bit.
REQ-009 Port sout_valid, output, 1: sout carries a valid data bit this cycle.
REQ-010 Port done, output, 1: pulse marking the cycle in which the last bit of a word is on sout.
REQ-011 Port busy, output, 1: a word is being shifted (state SHIFT).

Function
REQ-012 FSM SHALL have two states, IDLE and SHIFT, plus a shift register (WIDTH bits) and a bit counter (clog2(WIDTH) bits).
REQ-013 IDLE: ready=1, busy=0, sout_valid=0, sout=0, done=0.
REQ-014 Load handshake: ld=1 and ready=1 at a rising edge SHALL capture pin, set counter=WIDTH-1, and enter SHIFT.
REQ-015 Latency: for a word accepted at edge N, the first bit SHALL be on sout from edge N until edge N+1, and the last bit from edge N+WIDTH-1 until edge N+WIDTH.
REQ-016 SHIFT: sout_valid=1, busy=1; sout is the current head bit per MSB_FIRST; each edge advances one bit and decrements the counter.
REQ-017 ready SHALL be 0 in SHIFT except in the last-bit cycle (counter==0), where ready=1.
REQ-018 done SHALL be 1 exactly in the last-bit cycle (SHIFT, counter==0), decoded from registered state only.
REQ-019 Last-bit cycle with ld=1: SHALL capture the new pin, reload counter=WIDTH-1, and stay in SHIFT, giving a gapless back-to-back stream.
REQ-020 Last-bit cycle with ld=0: SHALL return to IDLE; sout_valid=0 from the next cycle.
REQ-021 ld while ready=0 SHALL be ignored with no side effects; changes on pin during SHIFT SHALL NOT alter the word in flight.
REQ-022 sout SHALL be driven 0 whenever sout_valid=0.
REQ-023 ld held high continuously SHALL produce a continuous stream, one word per WIDTH cycles, re-sampling pin at each last-bit edge.

Reset
REQ-024 rst=0 SHALL asynchronously force state=IDLE, shift register=0, and counter=0.
REQ-025 While rst=0, outputs SHALL be ready=0, sout=0, sout_valid=0, done=0, busy=0; ready rises to 1 only after rst returns to 1.
REQ-026 Reset during SHIFT SHALL abort the word; no further bits of it are emitted and done is not pulsed for it.
REQ-027 ld=1 on the first edge after rst deasserts SHALL be accepted normally.

Verification
REQ-028 WIDTH=4, MSB_FIRST=1: ld pulse with pin=1010 -> sout 1,0,1,0 on the next 4 cycles; sout_valid high 4 cycles; done high on the 4th; then IDLE with ready=1.
REQ-029 Back-to-back: 1010 accepted, ld=1 with pin=0101 during the last-bit cycle -> 8 gapless valid bits 1,0,1,0,0,1,0,1; done pulses on cycles 4 and 8; busy never drops.
REQ-030 Busy ignore: pin=1101 accepted, then ld=1 with pin=0000 in cycles 1-2 of the shift -> output remains 1,1,0,1; no extra word is sent.
REQ-031 MSB_FIRST=0: pin=1101 -> sout 1,0,1,1.
REQ-032 Reset mid-word: rst=0 asserted between edges during bit 2 of 1011 -> all outputs 0 immediately; after release ready=1; a new load of 0110 transmits cleanly.
REQ-033 Continuous ld=1 with pin changing every cycle -> only the values present at the last-bit edges are transmitted, with one done pulse per 4 cycles.
